// File: rtl/cv32e40p_apu_resp.sv
// cv32e40p_apu_resp: APU response unit with three latency classes.
// Class 0/1 add/sub answers in the grant cycle, class 2 multiply-add
// goes through a PIPE_DEPTH pipeline, class 3 divides in an FSM.
// Ports: clk_i/rst_ni (async active-low); apu_req_i/apu_gnt_o request
// handshake; apu_lat_i class; apu_op_i add/sub; apu_operands_i a=[0],
// b=[1], c=[2]; apu_tag_i tag; apu_rvalid_o/result/tag/flags response;
// busy_o any request in flight.
// Macro CV32E40P_APU_RESP_DIV_EN compiles in the iterative divider;
// without it a class-3 request answers result 0 with flags bit1 set.
module cv32e40p_apu_resp #(
    parameter int WIDTH      = 32,
    parameter int PIPE_DEPTH = 2,
    parameter int TAG_W      = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  apu_req_i,
    output logic                  apu_gnt_o,
    input  logic [1:0]            apu_lat_i,
    input  logic                  apu_op_i,
    input  logic [2:0][WIDTH-1:0] apu_operands_i,
    input  logic [TAG_W-1:0]      apu_tag_i,
    output logic                  apu_rvalid_o,
    output logic [WIDTH-1:0]      apu_result_o,
    output logic [TAG_W-1:0]      apu_tag_o,
    output logic [1:0]            apu_flags_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] op_a, op_b, op_c;
    logic [WIDTH-1:0] res_1, mac;
    logic             idle, pipe_empty;
    logic             gnt_1, gnt_2, gnt_3;

    logic [PIPE_DEPTH-1:0] pv_q;
    logic [WIDTH-1:0]      pr_q [PIPE_DEPTH];
    logic [TAG_W-1:0]      pt_q [PIPE_DEPTH];

    logic [TAG_W-1:0] ftag_q;
    logic [WIDTH-1:0] fres;
    logic [1:0]       fflags;

    assign op_a = apu_operands_i[0];
    assign op_b = apu_operands_i[1];
    assign op_c = apu_operands_i[2];

    assign res_1 = apu_op_i ? (op_a - op_b) : (op_a + op_b);
    assign mac   = op_a * op_b + op_c;

    assign idle       = (state_q == IDLE);
    assign pipe_empty = ~|pv_q;

    // Class 2 may stream behind itself; class 0/1/3 need a quiet unit
    // so their single response slot cannot collide with the pipeline.
    assign gnt_1 = rst_ni & apu_req_i & ~apu_lat_i[1] & idle & pipe_empty;
    assign gnt_2 = rst_ni & apu_req_i & (apu_lat_i == 2'd2) & idle;
    assign gnt_3 = rst_ni & apu_req_i & (apu_lat_i == 2'd3) & idle
                 & pipe_empty;

    assign apu_gnt_o = gnt_1 | gnt_2 | gnt_3;
    assign busy_o    = ~pipe_empty | ~idle;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv_q <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pr_q[i] <= '0;
                pt_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= gnt_2;
            pr_q[0] <= gnt_2 ? mac : '0;
            pt_q[0] <= gnt_2 ? apu_tag_i : '0;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pv_q[i] <= pv_q[i-1];
                pr_q[i] <= pr_q[i-1];
                pt_q[i] <= pt_q[i-1];
            end
        end
    end

`ifdef CV32E40P_APU_RESP_DIV_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
    logic [1:0]       flags_q;
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] sub;
    logic             fits;

    // Restoring step: shift the next dividend bit into the remainder
    // and keep the subtraction only when the divisor fits.
    assign sh   = {rem_q, quo_q[WIDTH-1]};
    assign fits = (sh >= {1'b0, dvs_q});
    assign sub  = WIDTH'(sh - {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (gnt_3) state_d = (op_b == '0) ? DONE : DIV;
            DIV:  if (cnt_q == '0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            flags_q <= '0;
            ftag_q  <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_3) begin
                cnt_q   <= CW'(WIDTH - 1);
                quo_q   <= (op_b == '0) ? '1 : op_a;
                rem_q   <= '0;
                dvs_q   <= op_b;
                flags_q <= {1'b0, op_b == '0};
                ftag_q  <= apu_tag_i;
            end else if (state_q == DIV) begin
                cnt_q <= cnt_q - 1'b1;
                quo_q <= {quo_q[WIDTH-2:0], fits};
                rem_q <= fits ? sub : sh[WIDTH-1:0];
            end
        end
    end

    assign fres   = quo_q;
    assign fflags = flags_q;
`else
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (gnt_3) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ftag_q  <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_3) ftag_q <= apu_tag_i;
        end
    end

    assign fres   = '0;
    assign fflags = 2'b10;
`endif

    // Grant rules leave at most one of these sources active per cycle.
    always_comb begin
        apu_rvalid_o = 1'b0;
        apu_result_o = '0;
        apu_tag_o    = '0;
        apu_flags_o  = '0;
        if (pv_q[PIPE_DEPTH-1]) begin
            apu_rvalid_o = 1'b1;
            apu_result_o = pr_q[PIPE_DEPTH-1];
            apu_tag_o    = pt_q[PIPE_DEPTH-1];
        end else if (state_q == DONE) begin
            apu_rvalid_o = 1'b1;
            apu_result_o = fres;
            apu_tag_o    = ftag_q;
            apu_flags_o  = fflags;
        end else if (gnt_1) begin
            apu_rvalid_o = 1'b1;
            apu_result_o = res_1;
            apu_tag_o    = apu_tag_i;
        end
    end

endmodule

// File: tb/tb_cv32e40p_apu_resp.sv
// tb_cv32e40p_apu_resp: directed bench for cv32e40p_apu_resp.
// Vector table for single-cycle classes, hand sequences for the rest.
module tb_cv32e40p_apu_resp;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req;
    logic             gnt;
    logic [1:0]       lat;
    logic             op;
    logic [2:0][31:0] ops;
    logic [5:0]       tag_in;
    logic             rvalid;
    logic [31:0]      result;
    logic [5:0]       tag_out;
    logic [1:0]       flags;
    logic             busy;

    int n_run  = 0;
    int n_fail = 0;

    cv32e40p_apu_resp dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .apu_req_i      (req),
        .apu_gnt_o      (gnt),
        .apu_lat_i      (lat),
        .apu_op_i       (op),
        .apu_operands_i (ops),
        .apu_tag_i      (tag_in),
        .apu_rvalid_o   (rvalid),
        .apu_result_o   (result),
        .apu_tag_o      (tag_out),
        .apu_flags_o    (flags),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [1:0]  lat;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  tag;
        logic        gnt;
        logic        rv;
        logic [31:0] res;
        logic [5:0]  etag;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic r, input logic [1:0] l, input logic o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [5:0] t);
        req    = r;
        lat    = l;
        op     = o;
        ops[0] = a;
        ops[1] = b;
        ops[2] = c;
        tag_in = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        drv(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 6'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_k;
        int rv_cnt;
        logic gnt_seen;
        logic [31:0] r_res;
        logic [5:0] r_tag;
        logic [1:0] r_flg;

        vt[0] = '{1'b1, 2'd1, 1'b0, 32'd5, 32'd7, 6'd3,
                  1'b1, 1'b1, 32'd12, 6'd3};
        vt[1] = '{1'b1, 2'd1, 1'b1, 32'd10, 32'd3, 6'd17,
                  1'b1, 1'b1, 32'd7, 6'd17};
        vt[2] = '{1'b1, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 6'd63,
                  1'b1, 1'b1, 32'd0, 6'd63};
        vt[3] = '{1'b1, 2'd0, 1'b1, 32'd0, 32'd1, 6'd1,
                  1'b1, 1'b1, 32'hFFFF_FFFF, 6'd1};
        vt[4] = '{1'b0, 2'd1, 1'b0, 32'd5, 32'd7, 6'd3,
                  1'b0, 1'b0, 32'd0, 6'd0};
        vt[5] = '{1'b1, 2'd0, 1'b0, 32'd100, 32'd23, 6'd40,
                  1'b1, 1'b1, 32'd123, 6'd40};

        // reset behaviour with a pending request
        rst_n = 1'b0;
        drv(1'b1, 2'd0, 1'b0, 32'd5, 32'd7, 32'd0, 6'd3);
        #2;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_tag", 32'(tag_out), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        tick();
        tick();
        idle_in();
        rst_n = 1'b1;
        tick();

        // single-cycle classes from the table
        for (int i = 0; i < 6; i++) begin
            drv(vt[i].req, vt[i].lat, vt[i].op, vt[i].a, vt[i].b,
                32'd0, vt[i].tag);
            #1;
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
            chk($sformatf("vec%0d_rv", i), 32'(rvalid), 32'(vt[i].rv));
            chk($sformatf("vec%0d_res", i), result, vt[i].res);
            chk($sformatf("vec%0d_tag", i), 32'(tag_out), 32'(vt[i].etag));
            chk($sformatf("vec%0d_flg", i), 32'(flags), 32'd0);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
            tick();
            idle_in();
        end

        // class-2 back-to-back, responses at cycles 2, 3, 4
        drv(1'b1, 2'd2, 1'b0, 32'd2, 32'd3, 32'd1, 6'd1);
        #1;
        chk("p_c0_gnt", 32'(gnt), 32'd1);
        chk("p_c0_rv", 32'(rvalid), 32'd0);
        tick();
        drv(1'b1, 2'd2, 1'b0, 32'd4, 32'd4, 32'd0, 6'd2);
        #1;
        chk("p_c1_gnt", 32'(gnt), 32'd1);
        chk("p_c1_rv", 32'(rvalid), 32'd0);
        chk("p_c1_busy", 32'(busy), 32'd1);
        tick();
        drv(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 6'd4);
        #1;
        chk("p_c2_gnt", 32'(gnt), 32'd1);
        chk("p_c2_rv", 32'(rvalid), 32'd1);
        chk("p_c2_res", result, 32'd7);
        chk("p_c2_tag", 32'(tag_out), 32'd1);
        tick();
        idle_in();
        #1;
        chk("p_c3_rv", 32'(rvalid), 32'd1);
        chk("p_c3_res", result, 32'd16);
        chk("p_c3_tag", 32'(tag_out), 32'd2);
        tick();
        chk("p_c4_rv", 32'(rvalid), 32'd1);
        chk("p_c4_res", result, 32'hFFFF_FFFE);
        chk("p_c4_tag", 32'(tag_out), 32'd4);
        tick();
        chk("p_c5_rv", 32'(rvalid), 32'd0);
        chk("p_c5_busy", 32'(busy), 32'd0);

        // class-1 held off while class 2 drains
        drv(1'b1, 2'd2, 1'b0, 32'd3, 32'd3, 32'd0, 6'd5);
        #1;
        chk("blk_c0_gnt", 32'(gnt), 32'd1);
        tick();
        drv(1'b1, 2'd1, 1'b0, 32'd1, 32'd1, 32'd0, 6'd6);
        #1;
        chk("blk_c1_gnt", 32'(gnt), 32'd0);
        chk("blk_c1_rv", 32'(rvalid), 32'd0);
        tick();
        chk("blk_c2_gnt", 32'(gnt), 32'd0);
        chk("blk_c2_rv", 32'(rvalid), 32'd1);
        chk("blk_c2_res", result, 32'd9);
        chk("blk_c2_tag", 32'(tag_out), 32'd5);
        tick();
        chk("blk_c3_gnt", 32'(gnt), 32'd1);
        chk("blk_c3_rv", 32'(rvalid), 32'd1);
        chk("blk_c3_res", result, 32'd2);
        chk("blk_c3_tag", 32'(tag_out), 32'd6);
        chk("blk_c3_busy", 32'(busy), 32'd0);
        tick();
        idle_in();
        tick();

`ifdef CV32E40P_APU_RESP_DIV_EN
        // 100 / 7 with a class-1 request pending throughout
        drv(1'b1, 2'd3, 1'b0, 32'd100, 32'd7, 32'd0, 6'd9);
        #1;
        chk("div_gnt", 32'(gnt), 32'd1);
        tick();
        rv_k = 0;
        gnt_seen = 1'b0;
        r_res = '0;
        r_tag = '0;
        r_flg = '0;
        for (int k = 1; k <= 40; k++) begin
            drv(1'b1, 2'd1, 1'b0, 32'd1, 32'd1, 32'd0, 6'd2);
            #1;
            if (gnt) gnt_seen = 1'b1;
            if (rvalid) begin
                rv_k  = k;
                r_res = result;
                r_tag = tag_out;
                r_flg = flags;
                break;
            end
            tick();
        end
        chk("div_latency", 32'(rv_k), 32'd33);
        chk("div_res", r_res, 32'd14);
        chk("div_tag", 32'(r_tag), 32'd9);
        chk("div_flags", 32'(r_flg), 32'd0);
        chk("div_c1_blocked", 32'(gnt_seen), 32'd0);
        tick();
        chk("div_after_gnt", 32'(gnt), 32'd1);
        chk("div_after_res", result, 32'd2);
        tick();
        idle_in();
        tick();

        // divide by zero
        drv(1'b1, 2'd3, 1'b0, 32'd55, 32'd0, 32'd0, 6'd7);
        #1;
        chk("dz_gnt", 32'(gnt), 32'd1);
        tick();
        idle_in();
        #1;
        chk("dz_rv", 32'(rvalid), 32'd1);
        chk("dz_res", result, 32'hFFFF_FFFF);
        chk("dz_flags", 32'(flags), 32'd1);
        chk("dz_tag", 32'(tag_out), 32'd7);
        tick();
        chk("dz_after_rv", 32'(rvalid), 32'd0);
        chk("dz_after_busy", 32'(busy), 32'd0);

        // reset in cycle 10 of a division
        drv(1'b1, 2'd3, 1'b0, 32'd100, 32'd7, 32'd0, 6'd9);
        #1;
        chk("rdiv_gnt", 32'(gnt), 32'd1);
        tick();
        idle_in();
        for (int k = 1; k < 10; k++) tick();
        chk("rdiv_busy_pre", 32'(busy), 32'd1);
`else
        // class 3 without divider
        drv(1'b1, 2'd3, 1'b0, 32'd100, 32'd7, 32'd0, 6'd9);
        #1;
        chk("nd_gnt", 32'(gnt), 32'd1);
        chk("nd_rv0", 32'(rvalid), 32'd0);
        tick();
        idle_in();
        #1;
        chk("nd_rv", 32'(rvalid), 32'd1);
        chk("nd_res", result, 32'd0);
        chk("nd_flags", 32'(flags), 32'd2);
        chk("nd_tag", 32'(tag_out), 32'd9);
        chk("nd_busy", 32'(busy), 32'd1);
        tick();
        chk("nd_after_rv", 32'(rvalid), 32'd0);
        chk("nd_after_busy", 32'(busy), 32'd0);

        // reset with a class-2 request in flight
        drv(1'b1, 2'd2, 1'b0, 32'd6, 32'd6, 32'd0, 6'd9);
        #1;
        chk("rpipe_gnt", 32'(gnt), 32'd1);
        tick();
        idle_in();
        chk("rpipe_busy_pre", 32'(busy), 32'd1);
`endif
        drv(1'b1, 2'd1, 1'b0, 32'd5, 32'd7, 32'd0, 6'd3);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_rv", 32'(rvalid), 32'd0);
        chk("mrst_gnt", 32'(gnt), 32'd0);
        tick();
        idle_in();
        rst_n = 1'b1;
        rv_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (rvalid) rv_cnt++;
            tick();
        end
        chk("mrst_no_resp", 32'(rv_cnt), 32'd0);
        chk("mrst_busy_post", 32'(busy), 32'd0);
        drv(1'b1, 2'd1, 1'b0, 32'd20, 32'd22, 32'd0, 6'd11);
        #1;
        chk("mrst_next_gnt", 32'(gnt), 32'd1);
        chk("mrst_next_res", result, 32'd42);
        chk("mrst_next_tag", 32'(tag_out), 32'd11);
        tick();
        idle_in();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e40p_apu_resp.md
CV32E40P_APU_RESP -- requirements
Module: cv32e40p_apu_resp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter PIPE_DEPTH, default 2, class-2 pipeline stages; legal range 1..4.
REQ-003 SHALL have parameter TAG_W, default 6, request tag width.
REQ-004 SHALL have port clk_i  input  1  clock.
REQ-005 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port apu_req_i  input  1  request valid.
REQ-007 SHALL have port apu_gnt_o  output  1  request accepted this cycle.
REQ-008 SHALL have port apu_lat_i  input  2  latency class (0/1 single, 2 pipelined, 3 iterative).
REQ-009 SHALL have port apu_op_i  input  1  class-1 select: 0 add, 1 sub.
REQ-010 SHALL have port apu_operands_i  input  3xWIDTH  operands a, b, c.
REQ-011 SHALL have port apu_tag_i  input  TAG_W  destination tag, echoed on response.
REQ-012 SHALL have port apu_rvalid_o  output  1  response valid, one-cycle pulse per request.
REQ-013 SHALL have port apu_result_o  output  WIDTH  result.
REQ-014 SHALL have port apu_tag_o  output  TAG_W  tag of returning request.
REQ-015 SHALL have port apu_flags_o  output  2  bit0 divide-by-zero, bit1 illegal class-3.
REQ-016 SHALL have port busy_o  output  1  any request in flight.

Function
REQ-017 SHALL compute: class 0/1 a+b or a-b (mod 2^WIDTH); class 2 a*b+c low WIDTH bits; class 3 unsigned a/b.
REQ-018 SHALL grant class 0/1 only when pipeline empty and FSM IDLE; rvalid_o, result, tag combinational in grant cycle.
REQ-019 SHALL grant class 2 whenever FSM IDLE, one per cycle, regardless of pipeline occupancy; rvalid exactly PIPE_DEPTH cycles after grant.
REQ-020 SHALL grant class 3 only when pipeline empty and FSM IDLE.
REQ-021 SHALL drive apu_gnt_o combinationally from apu_req_i, apu_lat_i and current state; gnt_o=0 when req_i=0.
REQ-022 SHALL return responses strictly in grant order, at most one rvalid per cycle; grant rules guarantee no collision.
REQ-023 SHALL implement FSM IDLE->DIV->DONE->IDLE; grant in IDLE loads a, b, tag and counter WIDTH-1.
REQ-024 DIV SHALL resolve one quotient bit per cycle (restoring), WIDTH cycles, then DONE; DONE asserts rvalid for one cycle; grant-to-rvalid WIDTH+1 cycles.
REQ-025 Divide-by-zero SHALL go IDLE->DONE directly (rvalid 1 cycle after grant), result all ones, flags bit0=1.
REQ-026 SHALL drive apu_result_o, apu_tag_o, apu_flags_o to 0 when apu_rvalid_o=0.
REQ-027 SHALL assert busy_o while any pipeline stage valid or FSM not IDLE; combinational class-1 path does not set busy_o.
REQ-028 SHALL ignore operand/tag changes after grant; captured values used.

Reset
REQ-029 rst_ni low SHALL asynchronously clear pipeline valids, data, FSM to IDLE, counter, captured operands.
REQ-030 During and after reset: apu_gnt_o=0 while rst_ni low, apu_rvalid_o=0, busy_o=0, result/tag/flags=0.
REQ-031 Reset mid-operation SHALL drop all in-flight requests; no response for them is ever produced.

Configuration
REQ-032 Macro CV32E40P_APU_RESP_DIV_EN defined: iterative divider and FSM per REQ-023..025 compiled in.
REQ-033 Macro undefined: no divider logic; class-3 granted per REQ-020, responds one cycle after grant, result 0, flags bit1=1, tag echoed.

Verification
REQ-034 Class 1 add a=5, b=7, tag=3, idle -> gnt=1, same-cycle rvalid=1, result=12, tag=3.
REQ-035 Class 2 back-to-back cycles 0,1,2 (a=2,b=3,c=1; a=4,b=4,c=0; a=0xFFFFFFFF,b=2,c=0) PIPE_DEPTH=2 -> rvalid cycles 2,3,4, results 7, 16, 0xFFFFFFFE, in order.
REQ-036 Class 3 a=100, b=7, tag=9, DIV_EN -> rvalid 33 cycles after grant, result 14, flags 0; class-1 request during DIV -> gnt=0 until FSM IDLE.
REQ-037 Class 3 b=0, DIV_EN -> rvalid 1 cycle after grant, result 0xFFFFFFFF, flags=01; without DIV_EN, any class 3 -> result 0, flags=10.
REQ-038 Class 1 request while class-2 stage valid -> gnt=0 until pipeline drains, then granted with same-cycle response.
REQ-039 rst_ni low at cycle 10 of class-3 division -> rvalid never asserted for that tag, busy_o=0, next request granted normally.
